// File: rtl/alu_pkg.sv
// Shared opcode encodings and types for the execute-stage ALU.
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t OP_AND = 3'b000;
    localparam alu_op_t OP_OR  = 3'b001;
    localparam alu_op_t OP_ADD = 3'b010;
    localparam alu_op_t OP_XOR = 3'b011;
    localparam alu_op_t OP_NOR = 3'b100;
    localparam alu_op_t OP_SRL = 3'b101;
    localparam alu_op_t OP_SUB = 3'b110;
    localparam alu_op_t OP_SLT = 3'b111;

    // ADD/SUB/SLT all share one adder; SLT needs a subtraction for its compare.
    function automatic logic op_is_sub(input alu_op_t op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared WIDTH-bit adder/subtractor: sum = a + b, or a + ~b + 1 when sub is set.
module alu_addsub #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   total;

    assign b_eff = sub ? ~b : b;
    assign total = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    assign sum   = total[WIDTH-1:0];
    assign carry = total[WIDTH];
    // Signed overflow: operands agree in sign but the result does not.
    assign ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_core.sv
// Execute-stage ALU with registered result and zero flag (1-cycle latency).
// Define ALU_OVERFLOW_EN to add the registered signed-overflow output.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       aluOP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             zero,
    output logic [WIDTH-1:0] bus_resultOP
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int SHW = $clog2(WIDTH);

    alu_op_t          op;
    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_ovf;
    logic             unused_carry;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;
    logic             zero_d;
    logic             zero_q;

    assign op           = alu_op_t'(aluOP);
    assign shamt        = B[SHW-1:0];
    assign unused_carry = as_carry;

    alu_addsub #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a    (A),
        .b    (B),
        .sub  (op_is_sub(op)),
        .sum  (as_sum),
        .carry(as_carry),
        .ovf  (as_ovf)
    );

    always_comb begin
        result_d = '0;
        case (op)
            OP_AND:  result_d = A & B;
            OP_OR:   result_d = A | B;
            OP_ADD:  result_d = as_sum;
            OP_XOR:  result_d = A ^ B;
            OP_NOR:  result_d = ~(A | B);
            OP_SRL:  result_d = A >> shamt;
            OP_SUB:  result_d = as_sum;
            // Sign of the difference corrected by overflow gives the true signed compare.
            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
            default: result_d = '0;
        endcase
    end

    assign zero_d = (result_d == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign bus_resultOP = result_q;
    assign zero         = zero_q;

`ifdef ALU_OVERFLOW_EN
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = ((op == OP_ADD) || (op == OP_SUB)) ? as_ovf : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core; expected values are hand-computed constants.
module tb_alu_core;

    localparam int W = 64;

    logic         clk;
    logic         rst;
    logic [2:0]   aluOP;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         zero;
    logic [W-1:0] bus_resultOP;
`ifdef ALU_OVERFLOW_EN
    logic         overflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    alu_core #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .aluOP       (aluOP),
        .A           (A),
        .B           (B),
        .zero        (zero),
        .bus_resultOP(bus_resultOP)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow    (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one operation away from the edge, then sample #1 after the next rising edge.
    task automatic step(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        aluOP = op;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        $display("op=%b A=%h B=%h -> result=%h zero=%b", op, a, b, bus_resultOP, zero);
    endtask

    initial begin
        rst   = 1'b1;
        aluOP = 3'b000;
        A     = '0;
        B     = '0;
        #2;
        check("reset_result", bus_resultOP, 64'h0);
        check("reset_zero", {63'b0, zero}, 64'h1);
`ifdef ALU_OVERFLOW_EN
        check("reset_ovf", {63'b0, overflow}, 64'h0);
`endif
        @(negedge clk);
        rst = 1'b0;

        step(3'b010, 64'h1, 64'h1);
        check("add_result", bus_resultOP, 64'h2);
        check("add_zero", {63'b0, zero}, 64'h0);

        step(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        check("add_wrap_result", bus_resultOP, 64'h0);
        check("add_wrap_zero", {63'b0, zero}, 64'h1);

        step(3'b110, 64'h1234, 64'h1234);
        check("sub_eq_result", bus_resultOP, 64'h0);
        check("sub_eq_zero", {63'b0, zero}, 64'h1);

        step(3'b110, 64'h5, 64'h7);
        check("sub_neg_result", bus_resultOP, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub_neg_zero", {63'b0, zero}, 64'h0);
`ifdef ALU_OVERFLOW_EN
        check("sub_neg_ovf", {63'b0, overflow}, 64'h0);
`endif

        // Outputs must hold until the next edge even after inputs change.
        @(negedge clk);
        aluOP = 3'b000;
        A     = 64'h0;
        B     = 64'h0;
        #1;
        check("hold_result", bus_resultOP, 64'hFFFF_FFFF_FFFF_FFFE);

        step(3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        check("slt_lt_result", bus_resultOP, 64'h1);
        check("slt_lt_zero", {63'b0, zero}, 64'h0);

        step(3'b111, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF);
        check("slt_ge_result", bus_resultOP, 64'h0);
        check("slt_ge_zero", {63'b0, zero}, 64'h1);

        step(3'b111, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF);
        check("slt_ovf_result", bus_resultOP, 64'h1);

        step(3'b000, 64'hAC, 64'h0F);
        check("and_result", bus_resultOP, 64'h0C);

        step(3'b001, 64'hAC, 64'h0F);
        check("or_result", bus_resultOP, 64'hAF);

        step(3'b011, 64'hAC, 64'h0F);
        check("xor_result", bus_resultOP, 64'hA3);

        step(3'b100, 64'h0, 64'h0);
        check("nor_result", bus_resultOP, 64'hFFFF_FFFF_FFFF_FFFF);
        check("nor_zero", {63'b0, zero}, 64'h0);

        step(3'b101, 64'h80, 64'h47);
        check("srl7_result", bus_resultOP, 64'h1);

        step(3'b101, 64'hDEAD_BEEF_0000_1234, 64'h40);
        check("srl0_result", bus_resultOP, 64'hDEAD_BEEF_0000_1234);

        step(3'b101, 64'h8000_0000_0000_0000, 64'h3F);
        check("srl63_result", bus_resultOP, 64'h1);

        step(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
        check("add_ovf_result", bus_resultOP, 64'h8000_0000_0000_0000);
`ifdef ALU_OVERFLOW_EN
        check("add_ovf_flag", {63'b0, overflow}, 64'h1);
        step(3'b110, 64'h8000_0000_0000_0000, 64'h1);
        check("sub_ovf_result", bus_resultOP, 64'h7FFF_FFFF_FFFF_FFFF);
        check("sub_ovf_flag", {63'b0, overflow}, 64'h1);
        step(3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        check("and_ovf_flag", {63'b0, overflow}, 64'h0);
`endif

        // Mid-stream reset clears outputs without waiting for a clock edge.
        step(3'b001, 64'h55, 64'h0);
        check("pre_rst_result", bus_resultOP, 64'h55);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_result", bus_resultOP, 64'h0);
        check("mid_rst_zero", {63'b0, zero}, 64'h1);
        @(negedge clk);
        rst = 1'b0;

        step(3'b010, 64'h3, 64'h4);
        check("post_rst_result", bus_resultOP, 64'h7);
        check("post_rst_zero", {63'b0, zero}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
